isqrt_rem: RTL and testbench

ISQRT_REM -- requirements
Module: isqrt_rem

---
 rtl/isqrt_rem_pkg.sv | 9 +
 rtl/isqrt_rem_step.sv | 27 ++
 rtl/isqrt_rem.sv | 99 +++++++++
 tb/tb_isqrt_rem.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/isqrt_rem_pkg.sv
// Shared types for the isqrt_rem remainder-producing integer square root.
package isqrt_rem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WORK = 1'b1
  } state_e;

endpackage

// File: rtl/isqrt_rem_step.sv
// One digit-by-digit square root iteration: trial compare, conditional subtract, root shift.
module isqrt_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]                   i_rem,
  input  logic [WIDTH-1:0]                   i_root,
  input  logic [$clog2(WIDTH/2+1)-1:0]       i_cnt,
  output logic [WIDTH-1:0]                   o_rem,
  output logic [WIDTH-1:0]                   o_root
);

  localparam int CNT_W = $clog2(WIDTH/2+1);

  logic [CNT_W:0]     w_shamt;
  logic [WIDTH-1:0]   w_m;
  logic [WIDTH-1:0]   w_b;
  logic               w_ge;

  // The trial bit lands on an even position; the top trial (counter = WIDTH/2) is bit WIDTH-2.
  assign w_shamt = {i_cnt - CNT_W'(1), 1'b0};
  assign w_m     = {{(WIDTH-1){1'b0}}, 1'b1} << w_shamt;
  assign w_b     = i_root | w_m;
  assign w_ge    = (i_rem >= w_b);
  assign o_rem   = w_ge ? (i_rem - w_b) : i_rem;
  assign o_root  = (i_root >> 1) | (w_ge ? w_m : '0);

endmodule

// File: rtl/isqrt_rem.sv
// Sequential integer square root with remainder, one result bit per clock.
module isqrt_rem
  import isqrt_rem_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic               start_in,
  input  logic               abort_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [WIDTH/2-1:0] y_out,
  output logic [WIDTH/2:0]   rem_out
);

  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = $clog2(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HALF);

  state_e             r_state;
  state_e             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_root;
  logic [HALF-1:0]    r_y;
  logic [HALF:0]      r_remOut;
  logic               r_done;
  logic [WIDTH-1:0]   w_stepRem;
  logic [WIDTH-1:0]   w_stepRoot;
  logic               w_accept;
  logic               w_iter;
  logic               w_finish;

  isqrt_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_cnt  (r_cnt),
    .o_rem  (w_stepRem),
    .o_root (w_stepRoot)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  // Abort outranks both a pending completion and any start request.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (start_in) w_nextState = ST_WORK;
      ST_WORK: begin
        if (abort_in)            w_nextState = ST_IDLE;
        else if (r_cnt == '0)    w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_out = (r_state == ST_WORK);
    w_accept = (r_state == ST_IDLE) && start_in;
    w_iter   = (r_state == ST_WORK) && !abort_in && (r_cnt != '0);
    w_finish = (r_state == ST_WORK) && !abort_in && (r_cnt == '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_root   <= '0;
      r_y      <= '0;
      r_remOut <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_rem  <= a_in;
        r_root <= '0;
        r_cnt  <= CNT_INIT;
      end else if (w_iter) begin
        r_rem  <= w_stepRem;
        r_root <= w_stepRoot;
        r_cnt  <= r_cnt - CNT_W'(1);
      end else if (w_finish) begin
        r_y      <= r_root[HALF-1:0];
        r_remOut <= r_rem[HALF:0];
        r_done   <= 1'b1;
      end
    end
  end

  assign done_out = r_done;
  assign y_out    = r_y;
  assign rem_out  = r_remOut;

endmodule

// File: tb/tb_isqrt_rem.sv
// Self-checking bench for isqrt_rem at WIDTH=8 and WIDTH=16 against an arithmetic reference.
module tb_isqrt_rem;

  typedef struct {
    int          w;
    int unsigned a;
    int unsigned y;
    int unsigned r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a8;
  logic        start8, abort8, busy8, done8;
  logic [3:0]  y8;
  logic [4:0]  rem8;
  logic [15:0] a16;
  logic        start16, abort16, busy16, done16;
  logic [7:0]  y16;
  logic [8:0]  rem16;

  int nVec  = 0;
  int nMiss = 0;

  always #5 clk = ~clk;

  isqrt_rem #(.WIDTH(8)) u_dut8 (
    .clk_in(clk), .rst_in(rst), .a_in(a8), .start_in(start8), .abort_in(abort8),
    .busy_out(busy8), .done_out(done8), .y_out(y8), .rem_out(rem8)
  );

  isqrt_rem #(.WIDTH(16)) u_dut16 (
    .clk_in(clk), .rst_in(rst), .a_in(a16), .start_in(start16), .abort_in(abort16),
    .busy_out(busy16), .done_out(done16), .y_out(y16), .rem_out(rem16)
  );

  // Largest y with y*y <= a, found by plain counting.
  function automatic int unsigned refSqrt(input int unsigned a);
    int unsigned y = 0;
    while ((y + 1) * (y + 1) <= a) y++;
    return y;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nVec++;
    if (act != exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge with the DUT idle; lat counts edges from accept to done.
  task automatic applyStimulus8(input logic [7:0] a, output int y, output int r,
                                output int lat, output int busyCnt);
    a8 = a; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'($urandom);
    lat = 0; busyCnt = busy8 ? 1 : 0;
    while (lat < 40) begin
      tick(); lat++;
      if (busy8) busyCnt++;
      if (done8) break;
    end
    if (!done8) checkOutput("timeout8", 0, 1);
    y = y8; r = rem8;
  endtask

  task automatic applyStimulus16(input logic [15:0] a, output int y, output int r,
                                 output int lat, output int busyCnt);
    a16 = a; start16 = 1'b1;
    tick();
    start16 = 1'b0; a16 = 16'($urandom);
    lat = 0; busyCnt = busy16 ? 1 : 0;
    while (lat < 40) begin
      tick(); lat++;
      if (busy16) busyCnt++;
      if (done16) break;
    end
    if (!done16) checkOutput("timeout16", 0, 1);
    y = y16; r = rem16;
  endtask

  initial begin
    vec_t vecs[8];
    int y, r, lat, busyCnt, doneCnt;
    int unsigned ea, ey;
    logic [7:0] b2b[6];

    vecs[0] = '{8, 255, 15, 30};
    vecs[1] = '{8, 144, 12, 0};
    vecs[2] = '{8, 0, 0, 0};
    vecs[3] = '{16, 65535, 255, 510};
    vecs[4] = '{16, 1, 1, 0};
    vecs[5] = '{16, 100, 10, 0};
    vecs[6] = '{16, 50, 7, 1};
    vecs[7] = '{16, 200, 14, 4};

    rst = 1'b1; a8 = '0; start8 = 1'b0; abort8 = 1'b0;
    a16 = '0; start16 = 1'b0; abort16 = 1'b0;
    tick(); tick();
    checkOutput("rst busy8", busy8, 0);
    checkOutput("rst done8", done8, 0);
    checkOutput("rst y8", y8, 0);
    checkOutput("rst rem8", rem8, 0);
    checkOutput("rst busy16", busy16, 0);
    checkOutput("rst y16", y16, 0);
    checkOutput("rst rem16", rem16, 0);
    rst = 1'b0;
    tick();

    // Directed table with fixed latencies and busy lengths.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].w == 8) applyStimulus8(8'(vecs[i].a), y, r, lat, busyCnt);
      else                applyStimulus16(16'(vecs[i].a), y, r, lat, busyCnt);
      checkOutput($sformatf("tbl%0d y", i), y, vecs[i].y);
      checkOutput($sformatf("tbl%0d rem", i), r, vecs[i].r);
      checkOutput($sformatf("tbl%0d latency", i), lat, vecs[i].w / 2 + 1);
      checkOutput($sformatf("tbl%0d busyCycles", i), busyCnt, vecs[i].w / 2 + 1);
      tick();
      checkOutput($sformatf("tbl%0d donePulse", i), (vecs[i].w == 8) ? done8 : done16, 0);
    end

    // Second start during WORK must be ignored.
    a16 = 16'd100; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick(); tick();
    a16 = 16'd4; start16 = 1'b1;
    tick(); tick();
    start16 = 1'b0;
    doneCnt = 0; y = -1; r = -1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done16) begin doneCnt++; y = y16; r = rem16; end
    end
    checkOutput("ignoreStart doneCount", doneCnt, 1);
    checkOutput("ignoreStart y", y, 10);
    checkOutput("ignoreStart rem", r, 0);
    checkOutput("ignoreStart busy", busy16, 0);

    // Abort at iteration 2 keeps the previous result.
    applyStimulus16(16'd65535, y, r, lat, busyCnt);
    tick();
    a16 = 16'd200; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    abort16 = 1'b1;
    tick();
    abort16 = 1'b0;
    checkOutput("abort busy", busy16, 0);
    checkOutput("abort done", done16, 0);
    checkOutput("abort y", y16, 255);
    checkOutput("abort rem", rem16, 510);
    doneCnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done16) doneCnt++;
    end
    checkOutput("abort noDone", doneCnt, 0);
    applyStimulus16(16'd50, y, r, lat, busyCnt);
    checkOutput("afterAbort y", y, 7);
    checkOutput("afterAbort rem", r, 1);
    tick();

    // Abort in the completion cycle suppresses the result.
    a16 = 16'd9; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (8) tick();
    abort16 = 1'b1;
    tick();
    abort16 = 1'b0;
    checkOutput("lateAbort done", done16, 0);
    checkOutput("lateAbort busy", busy16, 0);
    checkOutput("lateAbort y", y16, 7);
    checkOutput("lateAbort rem", rem16, 1);
    tick();
    checkOutput("lateAbort noDone", done16, 0);

    // Reset mid-operation clears everything and never completes.
    a16 = 16'd65535; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRst busy", busy16, 0);
    checkOutput("midRst done", done16, 0);
    checkOutput("midRst y", y16, 0);
    checkOutput("midRst rem", rem16, 0);
    doneCnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done16) doneCnt++;
    end
    checkOutput("midRst noDone", doneCnt, 0);

    // Back-to-back: next start is issued in each done cycle.
    b2b[0] = 8'd255; b2b[1] = 8'd1; b2b[2] = 8'd2; b2b[3] = 8'd99;
    b2b[4] = 8'($urandom); b2b[5] = 8'($urandom);
    a8 = b2b[0]; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lat = 0;
      while (lat < 40) begin
        tick(); lat++;
        if (done8) break;
      end
      ey = refSqrt(b2b[i]);
      checkOutput($sformatf("b2b%0d latency", i), lat, 5);
      checkOutput($sformatf("b2b%0d y", i), y8, ey);
      checkOutput($sformatf("b2b%0d rem", i), rem8, b2b[i] - ey * ey);
      if (i < 5) begin
        a8 = b2b[i + 1]; start8 = 1'b1;
        tick();
        start8 = 1'b0;
      end
    end
    tick();

    // Exhaustive WIDTH=8 sweep.
    for (int a = 0; a < 256; a++) begin
      applyStimulus8(8'(a), y, r, lat, busyCnt);
      ey = refSqrt(a);
      checkOutput($sformatf("sweep%0d y", a), y, ey);
      checkOutput($sformatf("sweep%0d rem", a), r, a - ey * ey);
      tick();
    end

    // Random WIDTH=16 operands.
    for (int i = 0; i < 150; i++) begin
      ea = $urandom_range(0, 65535);
      applyStimulus16(16'(ea), y, r, lat, busyCnt);
      ey = refSqrt(ea);
      checkOutput($sformatf("rnd%0d y a=%0d", i, ea), y, ey);
      checkOutput($sformatf("rnd%0d rem a=%0d", i, ea), r, ea - ey * ey);
      checkOutput($sformatf("rnd%0d remBound", i), (r <= 2 * y) ? 1 : 0, 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
